// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request/grant bundle between the two producers and the arbiter,
// plus the register-file write port and the XZR-drop counter the arbiter drives.
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 5,
    parameter int DROP_CNT_WIDTH = 8
);
    logic                      req0_valid;
    logic                      req0_ready;
    logic [ADDR_WIDTH-1:0]     req0_reg;
    logic [DATA_WIDTH-1:0]     req0_data;
    logic                      req1_valid;
    logic                      req1_ready;
    logic [ADDR_WIDTH-1:0]     req1_reg;
    logic [DATA_WIDTH-1:0]     req1_data;
    logic                      regwrite;
    logic [ADDR_WIDTH-1:0]     writeReg;
    logic [DATA_WIDTH-1:0]     writeData;
    logic [DROP_CNT_WIDTH-1:0] drop_count;

    modport master (
        output req0_valid, req0_reg, req0_data,
        output req1_valid, req1_reg, req1_data,
        input  req0_ready, req1_ready,
        input  regwrite, writeReg, writeData, drop_count
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        input  req1_valid, req1_reg, req1_data,
        output req0_ready, req1_ready,
        output regwrite, writeReg, writeData, drop_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: ALU (req0) and load (req1) share the register-file write port; writes to X31 are dropped and counted.
// Latency: 1 cycle from handshake edge to write port. Backpressure only by losing arbitration; ready is combinational.
// WB_ARB_ROUND_ROBIN_EN defined: round-robin on contention; undefined: req1 always wins on contention.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 5,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] XZR_IDX = ADDR_WIDTH'(31);

    logic                      regwrite_q,   regwrite_d;
    logic [ADDR_WIDTH-1:0]     write_reg_q,  write_reg_d;
    logic [DATA_WIDTH-1:0]     write_data_q, write_data_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q,   drop_cnt_d;

    logic                      grant0;
    logic                      grant1;
    logic                      xfer;
    logic                      is_xzr;
    logic [ADDR_WIDTH-1:0]     sel_reg;
    logic [DATA_WIDTH-1:0]     sel_data;
    logic                      prio0;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // req0 is favoured exactly when req1 took the previous transfer
    assign prio0 = last_grant_q;

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign prio0 = 1'b0;
`endif

    always_comb begin
        grant0   = !reset && bus.req0_valid && (!bus.req1_valid || prio0);
        grant1   = !reset && bus.req1_valid && !grant0;
        xfer     = grant0 || grant1;
        sel_reg  = grant0 ? bus.req0_reg  : bus.req1_reg;
        sel_data = grant0 ? bus.req0_data : bus.req1_data;
        is_xzr   = (sel_reg == XZR_IDX);

        regwrite_d   = xfer && !is_xzr;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        drop_cnt_d   = drop_cnt_q;
        if (xfer) begin
            write_reg_d  = sel_reg;
            write_data_d = sel_data;
            if (is_xzr && (drop_cnt_q != {DROP_CNT_WIDTH{1'b1}})) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
            end
        end
    end

    // Async reset kills a pending write immediately, before the next edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            regwrite_q   <= regwrite_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.regwrite   = regwrite_q;
    assign bus.writeReg   = write_reg_q;
    assign bus.writeData  = write_data_q;
    assign bus.drop_count = drop_cnt_q;
endmodule
